fpga_rst_sequencer: RTL and testbench

FPGA_RST_SEQUENCER -- requirements
Module: fpga_rst_sequencer

---
 rtl/fpga_rst_sequencer.sv | 140 ++++++++++++++
 tb/tb_fpga_rst_sequencer.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/fpga_rst_sequencer.sv
// Reset sequencer for an MMCM-clocked SoC.
// Pulses the MMCM reset, waits for LOCKED, qualifies it over a stable window,
// holds the SoC in reset a little longer and then releases it. A lock loss or
// a pad reset restarts the sequence. A single shared counter times every
// phase and is cleared on every state change.
module fpga_rst_sequencer #(
   parameter int unsigned MMCM_RST_CYCLES     = 16,
   parameter int unsigned LOCK_STABLE_CYCLES  = 1024,
   parameter int unsigned LOCK_TIMEOUT_CYCLES = 65536,
   parameter int unsigned SOC_HOLD_CYCLES     = 32
) (
   input  logic       clk_i,
   input  logic       rst_ni,
   input  logic       pad_reset_i,
   input  logic       mmcm_locked_i,
   output logic       mmcm_rst_o,
   output logic       soc_rst_no,
   output logic [2:0] state_o,
   output logic [7:0] relock_cnt_o,
   output logic       timeout_o
);

   localparam int unsigned MAX_AB  = (MMCM_RST_CYCLES > LOCK_STABLE_CYCLES) ?
                                     MMCM_RST_CYCLES : LOCK_STABLE_CYCLES;
   localparam int unsigned MAX_CD  = (LOCK_TIMEOUT_CYCLES > SOC_HOLD_CYCLES) ?
                                     LOCK_TIMEOUT_CYCLES : SOC_HOLD_CYCLES;
   localparam int unsigned MAX_P   = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
   localparam int unsigned CNT_W   = $clog2(MAX_P) + 1;

   // Terminal counts: the counter runs 0..N-1, so a phase lasts N cycles.
   localparam logic [CNT_W-1:0] MMCM_LAST    = CNT_W'(MMCM_RST_CYCLES - 1);
   localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);
   localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
   localparam logic [CNT_W-1:0] HOLD_LAST    = CNT_W'(SOC_HOLD_CYCLES - 1);

   typedef enum logic [2:0] {
      ST_MMCM_RST  = 3'd0,
      ST_WAIT_LOCK = 3'd1,
      ST_STABLE    = 3'd2,
      ST_SOC_HOLD  = 3'd3,
      ST_RUN       = 3'd4
   } state_t;

   state_t           state_reg, state_next;
   logic [CNT_W-1:0] cnt_reg, cnt_next;
   logic [7:0]       relock_cnt_reg, relock_cnt_next;
   logic             timeout_reg, timeout_next;
   logic             mmcm_rst_reg, soc_rst_n_reg;
   logic [1:0]       pad_sync_reg, lock_sync_reg;
   logic             pad_s, lock_s;

   assign pad_s  = pad_sync_reg[1];
   assign lock_s = lock_sync_reg[1];

   // Two-flop synchronizers for the asynchronous pad reset and LOCKED inputs.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         pad_sync_reg  <= 2'b00;
         lock_sync_reg <= 2'b00;
      end else begin
         pad_sync_reg  <= {pad_sync_reg[0], pad_reset_i};
         lock_sync_reg <= {lock_sync_reg[0], mmcm_locked_i};
      end
   end

   // Next-state, shared counter, relock counter and sticky timeout.
   always_comb begin
      state_next      = state_reg;
      cnt_next        = cnt_reg + 1'b1;
      relock_cnt_next = relock_cnt_reg;
      timeout_next    = timeout_reg;

      if (pad_s) begin
         // Pad reset wins over everything, including a simultaneous lock loss.
         state_next = ST_MMCM_RST;
      end else begin
         case (state_reg)
            ST_MMCM_RST: begin
               if (cnt_reg == MMCM_LAST) state_next = ST_WAIT_LOCK;
            end
            ST_WAIT_LOCK: begin
               if (lock_s) begin
                  state_next = ST_STABLE;
               end else if (cnt_reg == TIMEOUT_LAST) begin
                  timeout_next = 1'b1;
                  state_next   = ST_MMCM_RST;
               end
            end
            ST_STABLE: begin
               if (!lock_s)                     state_next = ST_WAIT_LOCK;
               else if (cnt_reg == STABLE_LAST) state_next = ST_SOC_HOLD;
            end
            ST_SOC_HOLD: begin
               if (!lock_s)                   state_next = ST_WAIT_LOCK;
               else if (cnt_reg == HOLD_LAST) state_next = ST_RUN;
            end
            ST_RUN: begin
               // Nothing is timed in RUN; park the counter.
               cnt_next = cnt_reg;
               if (!lock_s) begin
                  if (relock_cnt_reg != 8'hFF) relock_cnt_next = relock_cnt_reg + 8'd1;
                  state_next = ST_MMCM_RST;
               end
            end
            default: state_next = ST_MMCM_RST;
         endcase
      end

      // Every transition starts the next phase from zero; a held pad reset
      // keeps the MMCM reset phase pinned at zero.
      if (pad_s || (state_next != state_reg)) cnt_next = '0;
   end

   // State and output registers; outputs decode the next state so they
   // change on the same edge as the state itself and never glitch.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_reg      <= ST_MMCM_RST;
         cnt_reg        <= '0;
         relock_cnt_reg <= 8'd0;
         timeout_reg    <= 1'b0;
         mmcm_rst_reg   <= 1'b1;
         soc_rst_n_reg  <= 1'b0;
      end else begin
         state_reg      <= state_next;
         cnt_reg        <= cnt_next;
         relock_cnt_reg <= relock_cnt_next;
         timeout_reg    <= timeout_next;
         mmcm_rst_reg   <= (state_next == ST_MMCM_RST);
         soc_rst_n_reg  <= (state_next == ST_RUN);
      end
   end

   assign mmcm_rst_o   = mmcm_rst_reg;
   assign soc_rst_no   = soc_rst_n_reg;
   assign state_o      = state_reg;
   assign relock_cnt_o = relock_cnt_reg;
   assign timeout_o    = timeout_reg;

endmodule

// File: tb/tb_fpga_rst_sequencer.sv
// Directed bench for fpga_rst_sequencer with shortened timing parameters.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_fpga_rst_sequencer;

   localparam int unsigned M_CYC = 16;
   localparam int unsigned S_CYC = 20;
   localparam int unsigned T_CYC = 200;
   localparam int unsigned H_CYC = 6;

   logic       clk_i = 1'b0;
   logic       rst_ni = 1'b0;
   logic       pad_reset_i = 1'b0;
   logic       mmcm_locked_i = 1'b0;
   logic       mmcm_rst_o;
   logic       soc_rst_no;
   logic [2:0] state_o;
   logic [7:0] relock_cnt_o;
   logic       timeout_o;

   int n_checks = 0;
   int n_pass   = 0;
   int k;

   fpga_rst_sequencer #(
      .MMCM_RST_CYCLES     (M_CYC),
      .LOCK_STABLE_CYCLES  (S_CYC),
      .LOCK_TIMEOUT_CYCLES (T_CYC),
      .SOC_HOLD_CYCLES     (H_CYC)
   ) dut (
      .clk_i         (clk_i),
      .rst_ni        (rst_ni),
      .pad_reset_i   (pad_reset_i),
      .mmcm_locked_i (mmcm_locked_i),
      .mmcm_rst_o    (mmcm_rst_o),
      .soc_rst_no    (soc_rst_no),
      .state_o       (state_o),
      .relock_cnt_o  (relock_cnt_o),
      .timeout_o     (timeout_o)
   );

   // 100 MHz board clock.
   always #5 clk_i = ~clk_i;

   // Counts one comparison and reports it.
   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs === exp) begin
         n_pass++;
         $display("[%0t] %s: got %0d ok", $time, tag, obs);
      end else begin
         $display("[%0t] FAIL %s: got %0d, expected %0d", $time, tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk_i);
   endtask

   // Each wait returns the number of falling edges until the level is seen,
   // or the bound if it never appears.
   task automatic wait_soc(input logic lvl, input int bound, output int cnt);
      cnt = 0;
      while (soc_rst_no !== lvl && cnt < bound) begin
         @(negedge clk_i);
         cnt++;
      end
   endtask

   task automatic wait_mmcm(input logic lvl, input int bound, output int cnt);
      cnt = 0;
      while (mmcm_rst_o !== lvl && cnt < bound) begin
         @(negedge clk_i);
         cnt++;
      end
   endtask

   task automatic wait_state(input logic [2:0] st, input int bound, output int cnt);
      cnt = 0;
      while (state_o !== st && cnt < bound) begin
         @(negedge clk_i);
         cnt++;
      end
   endtask

   // Stimulus sequence.
   initial begin
      // Reset values while rst_ni is held low.
      tick(3);
      check("rst_state",  state_o, 0);
      check("rst_mmcm",   mmcm_rst_o, 1);
      check("rst_soc",    soc_rst_no, 0);
      check("rst_relock", relock_cnt_o, 0);
      check("rst_tmo",    timeout_o, 0);

      // Nominal bring-up: MMCM reset lasts M_CYC cycles after release.
      rst_ni = 1'b1;
      wait_mmcm(1'b0, 1000, k);
      check("nom_mmcm_len", k, M_CYC);
      check("nom_wait_state", state_o, 1);
      tick(100);
      check("nom_still_wait", state_o, 1);
      check("nom_no_tmo", timeout_o, 0);
      // Lock rises: 2 sync + 1 detect + stable window + hold window.
      mmcm_locked_i = 1'b1;
      wait_soc(1'b1, 1000, k);
      check("nom_soc_rise", k, 3 + S_CYC + H_CYC);
      check("nom_run_state", state_o, 4);
      check("nom_mmcm_low", mmcm_rst_o, 0);

      // Lock loss in RUN: SoC reset within 3 cycles, one relock counted.
      mmcm_locked_i = 1'b0;
      wait_soc(1'b0, 100, k);
      check("loss_soc_fall", k, 3);
      check("loss_state", state_o, 0);
      check("loss_relock", relock_cnt_o, 1);
      check("loss_mmcm", mmcm_rst_o, 1);

      // Relock, then a one-cycle lock glitch in the middle of STABLE.
      mmcm_locked_i = 1'b1;
      wait_state(3'd2, 1000, k);
      check("glitch_in_stable", state_o, 2);
      tick(S_CYC / 2);
      mmcm_locked_i = 1'b0;
      tick(1);
      mmcm_locked_i = 1'b1;
      tick(2);
      check("glitch_back_wait", state_o, 1);
      // Glitch reaches the FSM at edge 3; lock seen again at edge 4.
      wait_soc(1'b1, 1000, k);
      check("glitch_soc_rise", k, 1 + S_CYC + H_CYC);
      check("glitch_relock", relock_cnt_o, 1);

      // Five-cycle pad reset pulse in RUN.
      pad_reset_i = 1'b1;
      tick(5);
      pad_reset_i = 1'b0;
      check("pad_soc_low", soc_rst_no, 0);
      check("pad_mmcm_high", mmcm_rst_o, 1);
      // Counting restarts once the synchronized pad reset drops (2 cycles).
      wait_mmcm(1'b0, 1000, k);
      check("pad_mmcm_tail", k, M_CYC + 2);
      check("pad_relock", relock_cnt_o, 1);
      wait_soc(1'b1, 1000, k);
      check("pad_rerun", state_o, 4);

      // Pad reset and lock loss together: pad wins, no relock counted.
      pad_reset_i   = 1'b1;
      mmcm_locked_i = 1'b0;
      tick(6);
      check("both_state", state_o, 0);
      check("both_relock", relock_cnt_o, 1);
      pad_reset_i = 1'b0;

      // Lock never arrives: timeout after T_CYC cycles in WAIT_LOCK.
      wait_mmcm(1'b0, 1000, k);
      check("tmo_enter_wait", state_o, 1);
      check("tmo_flag_clear", timeout_o, 0);
      wait_mmcm(1'b1, 1000, k);
      check("tmo_len", k, T_CYC);
      check("tmo_flag_set", timeout_o, 1);
      wait_mmcm(1'b0, 1000, k);
      check("tmo_repeat_mmcm", k, M_CYC);
      check("tmo_sticky", timeout_o, 1);

      // Many lock losses saturate the relock counter.
      for (int i = 0; i < 300; i++) begin
         mmcm_locked_i = 1'b1;
         wait_soc(1'b1, 1000, k);
         mmcm_locked_i = 1'b0;
         wait_soc(1'b0, 100, k);
      end
      check("relock_sat", relock_cnt_o, 255);

      // Asynchronous reset in the middle of SOC_HOLD.
      mmcm_locked_i = 1'b1;
      wait_state(3'd3, 1000, k);
      check("hold_reached", state_o, 3);
      tick(2);
      #1 rst_ni = 1'b0;
      #1;
      check("arst_state",  state_o, 0);
      check("arst_mmcm",   mmcm_rst_o, 1);
      check("arst_soc",    soc_rst_no, 0);
      check("arst_relock", relock_cnt_o, 0);
      check("arst_tmo",    timeout_o, 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   // Guard against a hung sequence.
   initial begin
      #5ms;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "watchdog");
   end

endmodule
